trap_controller: RTL



---
 rtl/trap_controller_pkg.sv | 67 ++++++
 rtl/trap_controller.sv | 113 +++++++++++
 2 files changed

// File: rtl/trap_controller_pkg.sv
// ============================================================================
// trap_controller_pkg : trap codes, CSR addresses, mcause values, FSM states
// Revision: 1.0
// ============================================================================
`default_nettype none

package trap_controller_pkg;

  typedef enum logic [2:0] {
    TRAP_NONE       = 3'd0,
    TRAP_ECALL      = 3'd1,
    TRAP_EBREAK     = 3'd2,
    TRAP_MRET       = 3'd3,
    TRAP_ILLEGAL    = 3'd4,
    TRAP_MISALIGNED = 3'd5
  } trap_code_e;

  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVEC  = 12'h305;

  localparam int          CAUSE_W           = 4;
  localparam logic [3:0]  MCAUSE_ECALL      = 4'd11;
  localparam logic [3:0]  MCAUSE_EBREAK     = 4'd3;
  localparam logic [3:0]  MCAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0]  MCAUSE_MISALIGNED = 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_MEPC   = 3'd1,
    ST_WR_MCAUSE = 3'd2,
    ST_RD_MTVEC  = 3'd3,
    ST_RD_MEPC   = 3'd4,
    ST_DONE      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_EXC  = 2'd1,
    REQ_MRET = 2'd2
  } req_kind_e;

  // Reserved codes 6-7 fall into the default and behave as NONE.
  function automatic req_kind_e trap_kind(input logic [2:0] code);
    req_kind_e k;
    case (code)
      TRAP_ECALL, TRAP_EBREAK, TRAP_ILLEGAL, TRAP_MISALIGNED: k = REQ_EXC;
      TRAP_MRET:                                              k = REQ_MRET;
      default:                                                k = REQ_NONE;
    endcase
    return k;
  endfunction

  function automatic logic [CAUSE_W-1:0] trap_cause(input logic [2:0] code);
    logic [CAUSE_W-1:0] c;
    case (code)
      TRAP_ECALL:   c = MCAUSE_ECALL;
      TRAP_EBREAK:  c = MCAUSE_EBREAK;
      TRAP_ILLEGAL: c = MCAUSE_ILLEGAL;
      default:      c = MCAUSE_MISALIGNED;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trap_controller.sv
// ============================================================================
// trap_controller : stalls the pipeline on exception/MRET, sequences the
//                   machine-mode CSR accesses and issues the PC redirect.
// Revision: 1.0
// ============================================================================
`default_nettype none

module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      trap_status,
  input  logic [XLEN-1:0] EX_pc,
  input  logic [XLEN-1:0] csr_read_data,
  output logic [11:0]     csr_read_address,
  output logic            csr_write_enable,
  output logic [11:0]     csr_write_address,
  output logic [XLEN-1:0] csr_write_data,
  output logic            trap_done,
  output logic            pc_redirect,
  output logic [XLEN-1:0] trap_target
);

  localparam logic [XLEN-1:0] C_ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  state_e             state_q, state_d;
  logic [XLEN-1:0]    epc_q, epc_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [XLEN-1:0]    target_q, target_d;
  req_kind_e          w_kind;

  assign w_kind = trap_kind(trap_status);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      epc_q    <= '0;
      cause_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    epc_d             = epc_q;
    cause_d           = cause_q;
    target_d          = target_q;
    csr_read_address  = '0;
    csr_write_enable  = 1'b0;
    csr_write_address = '0;
    csr_write_data    = '0;
    trap_done         = 1'b0;
    pc_redirect       = 1'b0;
    trap_target       = '0;

    case (state_q)
      ST_IDLE: begin
        // Combinational so the stall begins in the detect cycle; masked in reset.
        trap_done = !reset || (w_kind == REQ_NONE);
        if (w_kind == REQ_EXC) begin
          epc_d   = EX_pc;
          cause_d = trap_cause(trap_status);
          state_d = ST_WR_MEPC;
        end else if (w_kind == REQ_MRET) begin
          state_d = ST_RD_MEPC;
        end
      end
      ST_WR_MEPC: begin
        csr_write_enable  = 1'b1;
        csr_write_address = CSR_MEPC;
        csr_write_data    = epc_q;
        state_d           = ST_WR_MCAUSE;
      end
      ST_WR_MCAUSE: begin
        csr_write_enable  = 1'b1;
        csr_write_address = CSR_MCAUSE;
        csr_write_data    = {{(XLEN-CAUSE_W){1'b0}}, cause_q};
        state_d           = ST_RD_MTVEC;
      end
      ST_RD_MTVEC: begin
        // Direct mode only: mtvec mode bits are discarded.
        csr_read_address = CSR_MTVEC;
        target_d         = csr_read_data & C_ALIGN_MASK;
        state_d          = ST_DONE;
      end
      ST_RD_MEPC: begin
        csr_read_address = CSR_MEPC;
        target_d         = csr_read_data & C_ALIGN_MASK;
        state_d          = ST_DONE;
      end
      ST_DONE: begin
        trap_done   = 1'b1;
        pc_redirect = 1'b1;
        trap_target = target_q;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire
